mips_controller: RTL and testbench
==================================

# mips_controller

Multicycle main control FSM for the 8-bit MIPS datapath. Sequences byte-wide instruction fetch, decode, execute, memory and writeback from the 6-bit opcode and the ALU zero flag, and drives every datapath enable and mux select. Its `aluop` output feeds the ALU control decoder:

- 00 = add
- 01 = subtract
- 10 = decode from funct

## Interface
- No parameters; encodings are fixed.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode, IR[31:26].
- `zero` in 1: ALU result == 0.
- `memread` out 1: memory read strobe.
- `memwrite` out 1: memory write strobe.
- `alusrca` out 1: 0 = PC, 1 = register A.
- `alusrcb` out 2: 00 = B, 01 = const 1, 10 = imm, 11 = imm branch offset.
- `aluop` out 2: 00 add, 01 sub, 10 funct.
- `pcsource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `pcen` out 1: PC load enable.
- `iord` out 1: 0 = PC address, 1 = ALUOut address.
- `irwrite` out 4: one-hot IR byte load, bit0 = IR[7:0].
- `regwrite` out 1: register file write.
- `regdst` out 1: 0 = rt, 1 = rd.
- `memtoreg` out 1: 0 = ALUOut, 1 = MDR.

## Operation
- **Opcodes:**
  - LB 100000
  - SB 101000
  - RTYPE 000000
  - BEQ 000100
  - J 000010
  - ADDI 001000
- **State register:** 4-bit, 15 states. Outputs are a Moore decode of state, except `pcen` = pcwrite | (pcwritecond & `zero`), which is combinational.
- **Default:** every output 0 unless listed below.
- **FETCH1..FETCH4:** `memread`=1, `alusrcb`=01, `aluop`=00, `pcsource`=00, pcwrite=1. `irwrite` = 0001, 0010, 0100, 1000 respectively. Transitions FETCH1→2→3→4→DECODE.
- **DECODE:** `alusrcb`=11, `aluop`=00 (branch target into ALUOut).
  - LB or SB → MEMADR
  - RTYPE → RTYPEEX
  - BEQ → BEQEX
  - J → JEX
  - ADDI → ADDIEX
  - any other opcode → FETCH1 (treated as NOP; no state written)
- **MEMADR:** `alusrca`=1, `alusrcb`=10, `aluop`=00. LB → LBRD, SB → SBWR.
- **LBRD:** `memread`=1, `iord`=1 → LBWR.
- **LBWR:** `regwrite`=1, `memtoreg`=1, `regdst`=0 → FETCH1.
- **SBWR:** `memwrite`=1, `iord`=1 → FETCH1.
- **RTYPEEX:** `alusrca`=1, `alusrcb`=00, `aluop`=10 → RTYPEWR.
- **RTYPEWR:** `regwrite`=1, `regdst`=1 → FETCH1.
- **BEQEX:** `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsource`=01, pcwritecond=1 → FETCH1.
- **JEX:** `pcsource`=10, pcwrite=1 → FETCH1.
- **ADDIEX:** `alusrca`=1, `alusrcb`=10, `aluop`=00 → ADDIWR.
- **ADDIWR:** `regwrite`=1, `regdst`=0, `memtoreg`=0 → FETCH1.
- **Unused state encoding:** next state = FETCH1; all outputs 0.
- `op` is sampled only in DECODE and MEMADR. It must be stable from FETCH4 onward (IR is loaded by then).

## Timing
- **Reset:** while `reset_n`=0, state = FETCH1, so outputs equal the FETCH1 decode: `memread`=1, `irwrite`=0001, `alusrcb`=01, `pcen`=1, all others 0.
  - The datapath PC is reset by the same `reset_n`, so `pcen` high during reset is harmless.
  - Deassertion is synchronous to `clk`. The first edge after release moves FETCH1→FETCH2.
- **Reset asserted mid-instruction:** immediate return to FETCH1. No further `regwrite`/`memwrite` pulse occurs.
- **Cycle counts, FETCH1 to return to FETCH1:**
  - LB 8
  - SB 7
  - RTYPE 7
  - ADDI 7
  - BEQ 6
  - J 6
  - illegal opcode 5
- **Single-cycle strobes:** `regwrite`, `memwrite` and each `irwrite` bit are high for exactly one cycle per instruction.
- **`pcen` in BEQEX:** follows `zero` within the same cycle (no register stage).
- **`pcen` total per instruction:** exactly 4 fetch cycles plus 1 (J, or BEQ taken).

## Test plan
- **Reset:** `reset_n`=0 → FETCH1 outputs (`irwrite`=0001, `memread`=1, `pcen`=1). Release → `irwrite` steps 0010, 0100, 1000 on successive edges.
- **R-type and ADDI:** `op`=000000 → RTYPEEX `aluop`=10, `alusrca`=1; next cycle `regwrite`=1, `regdst`=1; 7 cycles total. `op`=001000 → `aluop`=00, `alusrcb`=10, then `regwrite`=1, `regdst`=0.
- **Memory ops:** `op`=100000 → LBRD `memread`=1 & `iord`=1, then LBWR `regwrite`=1 & `memtoreg`=1; 8 cycles. `op`=101000 → SBWR `memwrite`=1 & `iord`=1; 7 cycles.
- **BEQ:** `zero`=1 → `pcen`=1 with `pcsource`=01 and `aluop`=01 in BEQEX. `zero`=0 → `pcen`=0. `zero` toggled within BEQEX → `pcen` tracks combinationally.
- **J and illegal opcode:** `op`=000010 → JEX `pcen`=1, `pcsource`=10; 6 cycles. `op`=111111 → DECODE then FETCH1; no `regwrite`/`memwrite` pulse.
- **Reset mid-operation:** `reset_n` pulsed low during RTYPEEX → state FETCH1 asynchronously; no `regwrite` pulse is observed.

Source files
------------

// File: rtl/mips_controller.sv
// Multicycle main control FSM for the 8-bit MIPS datapath: byte-wide fetch,
// decode and per-opcode execute/memory/writeback sequencing, Moore-decoded controls.
module mips_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg
);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    state_t state_q, state_d;
    logic   pcwrite_s;
    logic   pcwritecond_s;

    // State register; reset parks the machine in FETCH1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore decode of the datapath controls
    always_comb begin
        state_d       = FETCH1;
        memread       = 1'b0;
        memwrite      = 1'b0;
        alusrca       = 1'b0;
        alusrcb       = 2'b00;
        aluop         = 2'b00;
        pcsource      = 2'b00;
        iord          = 1'b0;
        irwrite       = 4'b0000;
        regwrite      = 1'b0;
        regdst        = 1'b0;
        memtoreg      = 1'b0;
        pcwrite_s     = 1'b0;
        pcwritecond_s = 1'b0;
        case (state_q)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread   = 1'b1;
                alusrcb   = 2'b01;
                pcwrite_s = 1'b1;
                case (state_q)
                    FETCH1:  begin irwrite = 4'b0001; state_d = FETCH2; end
                    FETCH2:  begin irwrite = 4'b0010; state_d = FETCH3; end
                    FETCH3:  begin irwrite = 4'b0100; state_d = FETCH4; end
                    FETCH4:  begin irwrite = 4'b1000; state_d = DECODE; end
                    default: begin irwrite = 4'b0000; state_d = FETCH1; end
                endcase
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LB) begin
                    state_d = LBRD;
                end else if (op == OP_SB) begin
                    state_d = SBWR;
                end else begin
                    state_d = FETCH1;
                end
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = LBWR;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH1;
            end
            SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                state_d  = FETCH1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = RTYPEWR;
            end
            RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH1;
            end
            BEQEX: begin
                alusrca       = 1'b1;
                aluop         = 2'b01;
                pcsource      = 2'b01;
                pcwritecond_s = 1'b1;
                state_d       = FETCH1;
            end
            JEX: begin
                pcsource  = 2'b10;
                pcwrite_s = 1'b1;
                state_d   = FETCH1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWR;
            end
            ADDIWR: begin
                regwrite = 1'b1;
                state_d  = FETCH1;
            end
            default: begin
                state_d = FETCH1;
            end
        endcase
    end

    // Branch resolution passes zero straight through, no register stage
    assign pcen = pcwrite_s | (pcwritecond_s & zero);

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: per-cycle control-word vectors for every
// opcode, plus hand-written sequences for BEQ zero tracking and mid-instruction reset.
module tb_mips_controller;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic       zero;
    logic       memread, memwrite, alusrca, pcen, iord, regwrite, regdst, memtoreg;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] irwrite;
    logic [17:0] got;

    int n_vec = 0;
    int n_err = 0;

    mips_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op       (op),
        .zero     (zero),
        .memread  (memread),
        .memwrite (memwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluop    (aluop),
        .pcsource (pcsource),
        .pcen     (pcen),
        .iord     (iord),
        .irwrite  (irwrite),
        .regwrite (regwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg)
    );

    // {memread,memwrite,alusrca,alusrcb,aluop,pcsource,pcen,iord,irwrite,regwrite,regdst,memtoreg}
    assign got = {memread, memwrite, alusrca, alusrcb, aluop, pcsource,
                  pcen, iord, irwrite, regwrite, regdst, memtoreg};

    localparam logic [17:0] W_F1   = {1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1,1'b0,4'b0001,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_F2   = {1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1,1'b0,4'b0010,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_F3   = {1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1,1'b0,4'b0100,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_F4   = {1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1,1'b0,4'b1000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_DEC  = {1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_MADR = {1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_LBRD = {1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_LBWR = {1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'b0000,1'b1,1'b0,1'b1};
    localparam logic [17:0] W_SBWR = {1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_RTEX = {1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_RTWR = {1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'b0000,1'b1,1'b1,1'b0};
    localparam logic [17:0] W_BEQT = {1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_BEQN = {1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_JEX  = {1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_ADEX = {1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0};
    localparam logic [17:0] W_ADWR = {1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'b0000,1'b1,1'b0,1'b0};

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ILL   = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic z, input logic [17:0] w);
        vec_t v;
        v.op = o;
        v.zero = z;
        v.exp = w;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input logic [5:0] o, input logic z);
        add(o, z, W_F1);
        add(o, z, W_F2);
        add(o, z, W_F3);
        add(o, z, W_F4);
        add(o, z, W_DEC);
    endtask

    // Leaves the DUT in FETCH1 just after a falling edge with reset released
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        op      = 6'b000000;
        zero    = 1'b0;
        #1 reset_n = 1'b0;

        // Reset state holds FETCH1 decode even across clock edges
        @(negedge clk);
        check("reset_f1", got, W_F1);
        @(negedge clk);
        check("reset_f1_hold", got, W_F1);

        // Each instruction's rows run back to back; the following FETCH1 row checks the cycle count
        add_fetch(OP_RTYPE, 1'b0); add(OP_RTYPE, 1'b0, W_RTEX); add(OP_RTYPE, 1'b0, W_RTWR);
        add_fetch(OP_ADDI, 1'b0);  add(OP_ADDI, 1'b0, W_ADEX);  add(OP_ADDI, 1'b0, W_ADWR);
        add_fetch(OP_LB, 1'b0);    add(OP_LB, 1'b0, W_MADR);    add(OP_LB, 1'b0, W_LBRD);
        add(OP_LB, 1'b0, W_LBWR);
        add_fetch(OP_SB, 1'b0);    add(OP_SB, 1'b0, W_MADR);    add(OP_SB, 1'b0, W_SBWR);
        add_fetch(OP_BEQ, 1'b1);   add(OP_BEQ, 1'b1, W_BEQT);
        add_fetch(OP_BEQ, 1'b0);   add(OP_BEQ, 1'b0, W_BEQN);
        add_fetch(OP_J, 1'b0);     add(OP_J, 1'b0, W_JEX);
        add_fetch(OP_ILL, 1'b0);
        add_fetch(OP_RTYPE, 1'b1); add(OP_RTYPE, 1'b1, W_RTEX); add(OP_RTYPE, 1'b1, W_RTWR);

        reset_n = 1'b1;
        foreach (vecs[i]) begin
            op   = vecs[i].op;
            zero = vecs[i].zero;
            #1;
            check($sformatf("vec%0d_op%b", i, vecs[i].op), got, vecs[i].exp);
            @(negedge clk);
        end
        check("table_wrap_f1", got, W_F1);

        // BEQ: pcen follows zero combinationally inside BEQEX
        do_reset();
        op = OP_BEQ;
        zero = 1'b0;
        repeat (5) @(negedge clk);
        #1 check("beq_zero0", got, W_BEQN);
        zero = 1'b1;
        #1 check("beq_zero1", got, W_BEQT);
        zero = 1'b0;
        #1 check("beq_zero_back0", got, W_BEQN);
        @(negedge clk);
        check("beq_return_f1", got, W_F1);

        // Reset in RTYPEEX: immediate FETCH1, writeback never happens
        do_reset();
        op = OP_RTYPE;
        zero = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rtex", got, W_RTEX);
        #2 reset_n = 1'b0;
        #1 check("mid_async_f1", got, W_F1);
        @(posedge clk);
        #1 check("mid_no_regwrite", got, W_F1);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("mid_release_f1", got, W_F1);
        @(negedge clk);
        check("mid_release_f2", got, W_F2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
